// File: rtl/shader_bypass_pkg.sv
// Shared types and defaults for the shader-core operand bypass and scoreboard logic.
// Forwarding stages are numbered from the youngest (EX, index 0) to the oldest (WB).
package shader_bypass_pkg;

    localparam int unsigned DEF_REG_IDX_W = 5;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NUM_SRC   = 3;
    localparam int unsigned DEF_NUM_STG   = 3;
    localparam int unsigned DEF_LAT_W     = 3;
    localparam bit          DEF_ZERO_REG  = 1'b1;

    // Stage index convention: lower index is younger.
    localparam int unsigned STG_YOUNGEST = 0;

    typedef logic [DEF_REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0]    data_t;

endpackage

// File: rtl/bypass_select.sv
// Per-source operand mux: youngest matching forwarding stage, else RF data.
// With ZERO_REG set, register 0 always resolves to zero and never reports a stage hit.
module bypass_select
    import shader_bypass_pkg::*;
#(
    parameter int unsigned REG_IDX_W = DEF_REG_IDX_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_STG   = DEF_NUM_STG,
    parameter bit          ZERO_REG  = DEF_ZERO_REG
) (
    input  logic [REG_IDX_W-1:0]         src_idx,
    input  logic [DATA_W-1:0]            rf_data,
    input  logic [NUM_STG-1:0]           stg_valid,
    input  logic [NUM_STG*REG_IDX_W-1:0] stg_dest_idx,
    input  logic [NUM_STG*DATA_W-1:0]    stg_data,
    output logic [DATA_W-1:0]            op_data,
    output logic                         stg_hit
);

    always_comb begin
        op_data = rf_data;
        stg_hit = 1'b0;
        // Walk from the oldest stage toward STG_YOUNGEST so the youngest match is applied last.
        for (int i = NUM_STG - 1; i >= 0; i--) begin
            if (stg_valid[i] && (stg_dest_idx[i*REG_IDX_W +: REG_IDX_W] == src_idx)) begin
                op_data = stg_data[i*DATA_W +: DATA_W];
                stg_hit = 1'b1;
            end
        end
        if (ZERO_REG && (src_idx == '0)) begin
            op_data = '0;
            stg_hit = 1'b0;
        end
    end

endmodule

// File: rtl/operand_bypass_scoreboard.sv
// Forwarding and hazard unit: per-register pending/latency scoreboard, issue stall,
// per-source bypass select and a registered operand bundle with valid/ready handshake.
module operand_bypass_scoreboard
    import shader_bypass_pkg::*;
#(
    parameter int unsigned REG_IDX_W = DEF_REG_IDX_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned NUM_STG   = DEF_NUM_STG,
    parameter int unsigned LAT_W     = DEF_LAT_W,
    parameter bit          ZERO_REG  = DEF_ZERO_REG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [NUM_SRC*REG_IDX_W-1:0] issue_src_idx,
    input  logic                         issue_wr_en,
    input  logic [REG_IDX_W-1:0]         issue_dest_idx,
    input  logic [LAT_W-1:0]             issue_lat,
    input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
    input  logic [NUM_STG-1:0]           stg_valid,
    input  logic [NUM_STG*REG_IDX_W-1:0] stg_dest_idx,
    input  logic [NUM_STG*DATA_W-1:0]    stg_data,
    input  logic                         wb_commit,
    input  logic [REG_IDX_W-1:0]         wb_commit_idx,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [NUM_SRC*DATA_W-1:0]    op_data,
    output logic                         hazard_err
);

    localparam int unsigned NUM_REG = 2 ** REG_IDX_W;

    logic [NUM_REG-1:0] pend_q, pend_d;
    logic [LAT_W-1:0]   cnt_q [NUM_REG];
    logic [LAT_W-1:0]   cnt_d [NUM_REG];

    logic [REG_IDX_W-1:0]      src_idx [NUM_SRC];
    logic [NUM_SRC-1:0]        src_hit;
    logic [NUM_SRC-1:0]        src_blocked;
    logic [NUM_SRC-1:0]        src_orphan;
    logic [NUM_SRC*DATA_W-1:0] sel_data;
    logic                      waw;
    logic                      fire;
    logic                      dest_track;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic src_zero;

        assign src_idx[k] = issue_src_idx[k*REG_IDX_W +: REG_IDX_W];
        assign src_zero   = ZERO_REG && (src_idx[k] == '0);
        assign src_blocked[k] = !src_zero && pend_q[src_idx[k]] && (cnt_q[src_idx[k]] != '0);
        // Pending with count expired but nothing on the bypass network to forward from.
        assign src_orphan[k] = !src_zero && pend_q[src_idx[k]] && (cnt_q[src_idx[k]] == '0)
                               && !src_hit[k];

        bypass_select #(
            .REG_IDX_W (REG_IDX_W),
            .DATA_W    (DATA_W),
            .NUM_STG   (NUM_STG),
            .ZERO_REG  (ZERO_REG)
        ) u_bypass_select (
            .src_idx      (src_idx[k]),
            .rf_data      (rf_data[k*DATA_W +: DATA_W]),
            .stg_valid    (stg_valid),
            .stg_dest_idx (stg_dest_idx),
            .stg_data     (stg_data),
            .op_data      (sel_data[k*DATA_W +: DATA_W]),
            .stg_hit      (src_hit[k])
        );
    end

    assign waw = issue_wr_en && pend_q[issue_dest_idx] && (cnt_q[issue_dest_idx] > issue_lat);
    assign issue_ready = !(|src_blocked) && !waw && (!op_valid || op_ready);
    assign fire        = issue_valid && issue_ready;
    assign dest_track  = issue_wr_en && !(ZERO_REG && (issue_dest_idx == '0));

    always_comb begin
        for (int r = 0; r < NUM_REG; r++) begin
            pend_d[r] = pend_q[r];
            cnt_d[r]  = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            if (wb_commit && (wb_commit_idx == REG_IDX_W'(r))) begin
                pend_d[r] = 1'b0;
            end
            // A new producer overrides the same-cycle commit and decrement.
            if (fire && dest_track && (issue_dest_idx == REG_IDX_W'(r))) begin
                pend_d[r] = 1'b1;
                cnt_d[r]  = issue_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            for (int r = 0; r < NUM_REG; r++) begin
                cnt_q[r] <= '0;
            end
            op_valid   <= 1'b0;
            op_data    <= '0;
            hazard_err <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            if (fire) begin
                op_valid <= 1'b1;
                op_data  <= sel_data;
            end else if (op_ready) begin
                op_valid <= 1'b0;
            end
            if (fire && (|src_orphan)) begin
                hazard_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_bypass_scoreboard.sv
// Directed and randomized checks of operand_bypass_scoreboard against a
// register-level behavioural model of the scoreboard, bypass and output handshake.
module tb_operand_bypass_scoreboard;

    localparam int W  = 5;
    localparam int D  = 32;
    localparam int NS = 3;
    localparam int NG = 3;
    localparam int LW = 3;
    localparam int NR = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic            issue_ready;
    logic [NS*W-1:0] issue_src_idx;
    logic            issue_wr_en;
    logic [W-1:0]    issue_dest_idx;
    logic [LW-1:0]   issue_lat;
    logic [NS*D-1:0] rf_data;
    logic [NG-1:0]   stg_valid;
    logic [NG*W-1:0] stg_dest_idx;
    logic [NG*D-1:0] stg_data;
    logic            wb_commit;
    logic [W-1:0]    wb_commit_idx;
    logic            op_valid;
    logic            op_ready;
    logic [NS*D-1:0] op_data;
    logic            hazard_err;

    always #5 clk = ~clk;

    operand_bypass_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_src_idx  (issue_src_idx),
        .issue_wr_en    (issue_wr_en),
        .issue_dest_idx (issue_dest_idx),
        .issue_lat      (issue_lat),
        .rf_data        (rf_data),
        .stg_valid      (stg_valid),
        .stg_dest_idx   (stg_dest_idx),
        .stg_data       (stg_data),
        .wb_commit      (wb_commit),
        .wb_commit_idx  (wb_commit_idx),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_data        (op_data),
        .hazard_err     (hazard_err)
    );

    // Behavioural model state
    bit              m_pend [NR];
    int              m_cnt  [NR];
    bit              m_ov;
    logic [NS*D-1:0] m_od;
    bit              m_haz;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int src_reg(input int k);
        return int'(issue_src_idx[k*W +: W]);
    endfunction

    function automatic bit stage_hit(input int r);
        for (int i = 0; i < NG; i++)
            if (stg_valid[i] && int'(stg_dest_idx[i*W +: W]) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [D-1:0] ref_operand(input int k);
        int r = src_reg(k);
        if (r == 0) return '0;
        for (int i = 0; i < NG; i++)
            if (stg_valid[i] && int'(stg_dest_idx[i*W +: W]) == r) return stg_data[i*D +: D];
        return rf_data[k*D +: D];
    endfunction

    function automatic bit ref_ready();
        int dst = int'(issue_dest_idx);
        for (int k = 0; k < NS; k++) begin
            int r = src_reg(k);
            if (r != 0 && m_pend[r] && m_cnt[r] > 0) return 1'b0;
        end
        if (issue_wr_en && m_pend[dst] && m_cnt[dst] > int'(issue_lat)) return 1'b0;
        return !m_ov || op_ready;
    endfunction

    task automatic do_cycle(output bit fired, input string tag);
        bit              rdy, f, haz;
        logic [NS*D-1:0] ops;
        @(negedge clk);
        rdy = ref_ready();
        check({tag, ".ready"}, {95'd0, issue_ready}, {95'd0, rdy});
        f   = issue_valid && rdy && !rst;
        haz = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int r = src_reg(k);
            ops[k*D +: D] = ref_operand(k);
            if (f && r != 0 && m_pend[r] && m_cnt[r] == 0 && !stage_hit(r)) haz = 1'b1;
        end
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_pend[r] = 1'b0;
                m_cnt[r]  = 0;
            end
            m_ov  = 1'b0;
            m_od  = '0;
            m_haz = 1'b0;
        end else begin
            for (int r = 0; r < NR; r++)
                if (m_cnt[r] > 0) m_cnt[r]--;
            if (wb_commit) m_pend[int'(wb_commit_idx)] = 1'b0;
            if (f && issue_wr_en && issue_dest_idx != 0) begin
                m_pend[int'(issue_dest_idx)] = 1'b1;
                m_cnt[int'(issue_dest_idx)]  = int'(issue_lat);
            end
            if (f) begin
                m_ov = 1'b1;
                m_od = ops;
            end else if (op_ready) begin
                m_ov = 1'b0;
            end
            if (haz) m_haz = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".op_valid"}, {95'd0, op_valid}, {95'd0, m_ov});
        check({tag, ".op_data"}, op_data, m_od);
        check({tag, ".hazard_err"}, {95'd0, hazard_err}, {95'd0, m_haz});
        fired = f;
    endtask

    function automatic logic [NS*W-1:0] pack3(input int a, input int b, input int c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    task automatic set_idle();
        rst            = 1'b0;
        issue_valid    = 1'b0;
        issue_src_idx  = '0;
        issue_wr_en    = 1'b0;
        issue_dest_idx = '0;
        issue_lat      = '0;
        rf_data        = {$urandom, $urandom, $urandom};
        stg_valid      = '0;
        stg_dest_idx   = '0;
        stg_data       = '0;
        wb_commit      = 1'b0;
        wb_commit_idx  = '0;
        op_ready       = 1'b1;
    endtask

    initial begin
        bit f;
        int n;
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(f, "reset");
        check("reset.hazard_zero", {95'd0, hazard_err}, 96'd0);

        // 1: r5 producer lat 2, consumer stalls until the count expires, then forwards stg0
        set_idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_dest_idx = 5; issue_lat = 2;
        do_cycle(f, "t1.prod");
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(5, 0, 0);
        stg_valid = 3'b001; stg_dest_idx = pack3(5, 0, 0); stg_data = {64'd0, 32'hA5};
        do_cycle(f, "t1.stall");
        check("t1.first_stalled", {95'd0, f}, 96'd0);
        n = 0;
        while (!f && n < 10) begin
            do_cycle(f, "t1.wait");
            n++;
        end
        check("t1.fired", {95'd0, f}, 96'd1);
        check("t1.src0", {64'd0, op_data[31:0]}, 96'hA5);

        // 2: two stages match, youngest wins
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(0, 7, 0);
        stg_valid = 3'b101; stg_dest_idx = pack3(7, 0, 7);
        stg_data = {32'h22, 32'h0, 32'h11};
        do_cycle(f, "t2");
        check("t2.youngest", {64'd0, op_data[63:32]}, 96'h11);

        // 3: WAW on r3 (cnt 4 vs lat 1): three stall cycles
        set_idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_dest_idx = 3; issue_lat = 4;
        do_cycle(f, "t3.first");
        issue_lat = 1;
        f = 1'b0;
        n = 0;
        while (!f && n < 10) begin
            do_cycle(f, "t3.waw");
            if (!f) n++;
        end
        check("t3.fired", {95'd0, f}, 96'd1);
        check("t3.stalls", 96'(n), 96'd3);

        // 4: consumer backpressure then back-to-back fire
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(1, 2, 4); op_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle(f, "t4.hold");
        op_ready = 1'b1;
        do_cycle(f, "t4.release");
        check("t4.fire1", {95'd0, f}, 96'd1);
        rf_data = {$urandom, $urandom, $urandom};
        do_cycle(f, "t4.b2b");
        check("t4.ov_held", {95'd0, op_valid}, 96'd1);

        // 5: commit of r9 and new producer of r9 in the same cycle
        set_idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_dest_idx = 9; issue_lat = 0;
        do_cycle(f, "t5.pre");
        issue_lat = 3; wb_commit = 1'b1; wb_commit_idx = 9;
        do_cycle(f, "t5.same");
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(9, 0, 0);
        do_cycle(f, "t5.blocked");
        check("t5.stalled", {95'd0, f}, 96'd0);

        // 6: orphaned pending source sets hazard_err; reset mid-stall clears everything
        set_idle();
        for (int i = 0; i < 3; i++) do_cycle(f, "t6.idle");
        issue_valid = 1'b1; issue_src_idx = pack3(9, 0, 0);
        do_cycle(f, "t6.orphan");
        check("t6.hazard", {95'd0, hazard_err}, 96'd1);
        set_idle();
        for (int i = 0; i < 2; i++) do_cycle(f, "t6.sticky");
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_dest_idx = 4; issue_lat = 4;
        do_cycle(f, "t6.prod");
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(4, 0, 0);
        do_cycle(f, "t6.stall");
        rst = 1'b1;
        do_cycle(f, "t6.rst");
        check("t6.rst_ov", {95'd0, op_valid}, 96'd0);
        check("t6.rst_haz", {95'd0, hazard_err}, 96'd0);
        rst = 1'b0;
        do_cycle(f, "t6.after");
        check("t6.unblocked", {95'd0, f}, 96'd1);

        // Register 0 is hardwired to zero even when a stage claims it
        set_idle();
        issue_valid = 1'b1; issue_src_idx = pack3(0, 0, 0);
        stg_valid = 3'b001; stg_dest_idx = pack3(0, 0, 0); stg_data = {64'd0, 32'hFFFFFFFF};
        do_cycle(f, "zero");
        check("zero.ops", op_data, 96'd0);

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            rst            = ($urandom_range(0, 63) == 0);
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_src_idx  = pack3($urandom_range(0, 7), $urandom_range(0, 7),
                                   $urandom_range(0, 7));
            issue_wr_en    = $urandom_range(0, 1) == 1;
            issue_dest_idx = W'($urandom_range(0, 7));
            issue_lat      = LW'($urandom_range(0, 4));
            rf_data        = {$urandom, $urandom, $urandom};
            stg_valid      = NG'($urandom_range(0, 7));
            stg_dest_idx   = pack3($urandom_range(0, 7), $urandom_range(0, 7),
                                   $urandom_range(0, 7));
            stg_data       = {$urandom, $urandom, $urandom};
            wb_commit      = $urandom_range(0, 1) == 1;
            wb_commit_idx  = W'($urandom_range(0, 7));
            op_ready       = ($urandom_range(0, 3) != 0);
            do_cycle(f, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
